// File: rtl/ram_ctrl_if.sv
// Request/response handshake between a system initiator and ram_ctrl.
// master = requester side, slave = the controller.
interface ram_ctrl_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_wr;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_wr, rsp_rdata
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_wr, rsp_rdata
  );
endinterface

// File: rtl/ram_ctrl.sv
// Single-transaction bus initiator for the single-port ram: sequences cs/rd/wr/addr,
// owns the shared data bus and returns read data or a write acknowledge.
//
// state | meaning
// IDLE  | req_ready=1, waiting for a request
// WRITE | one-cycle write strobe, data bus driven with latched wdata
// READ  | rd held RD_LATENCY cycles, data sampled on the last edge
// RESP  | response held until rsp_ready; bus turnaround cycle
module ram_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_ctrl_if.slave             bus,
  output logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data,
  output logic                  cs,
  output logic                  rd,
  output logic                  wr
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rsp_wr_q, rsp_wr_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  req_ready_q, req_ready_d;
  logic                  cs_q, cs_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rsp_wr_d = rsp_wr_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (bus.req_wr) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
            cnt_d   = 4'(RD_LATENCY - 1);
          end
        end
      end
      WRITE: begin
        state_d  = RESP;
        rsp_wr_d = 1'b1;
      end
      READ: begin
        if (cnt_q == 4'd0) begin
          rdata_d  = data;
          rsp_wr_d = 1'b0;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Strobes and handshake flags are registered copies of the next state.
    cs_d        = (state_d == WRITE) || (state_d == READ);
    rd_d        = (state_d == READ);
    wr_d        = (state_d == WRITE);
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_wr_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
      cs_q        <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_wr_q    <= rsp_wr_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
      cs_q        <= cs_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
    end
  end

  // Driver enable comes straight from the state register, so it can never overlap rd.
  assign data = (state_q == WRITE) ? wdata_q : {DATA_WIDTH{1'bz}};

  assign addr          = addr_q;
  assign cs            = cs_q;
  assign rd            = rd_q;
  assign wr            = wr_q;
  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_wr    = rsp_wr_q;
  assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: behavioural ram on the pins, array model of memory contents,
// directed scenarios followed by randomized transactions.
module tb_ram_ctrl;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int L  = 2;

  logic          clk;
  logic          rst;
  logic [AW-1:0] addr;
  wire  [DW-1:0] data;
  logic          cs, rd, wr;

  ram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(L)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .addr (addr),
    .data (data),
    .cs   (cs),
    .rd   (rd),
    .wr   (wr)
  );

  // Undriven bus floats high, so a released bus reads as all ones.
  for (genvar i = 0; i < DW; i++) begin : g_pu
    pullup (data[i]);
  end

  // Behavioural ram: drives data while selected for read, commits on write edges.
  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  logic          ram_clr;
  assign data = (cs && rd) ? ram_mem[addr] : {DW{1'bz}};

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < (1 << AW); i++) ram_mem[i] <= '0;
    end else if (cs && wr) begin
      ram_mem[addr] <= data;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int wr_cycles = 0;
  int rd_cycles = 0;
  bit mon_en = 1'b0;

  logic [DW-1:0] model_mem [0:(1<<AW)-1];
  logic [DW-1:0] last_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (wr) wr_cycles++;
      if (rd) rd_cycles++;
      check("rd_wr_exclusive", 32'(rd && wr), 32'd0);
      if (rd)       check("rd_bus_clean", 32'(data), 32'(ram_mem[addr]));
      else if (wr)  check("wr_data_known", 32'($isunknown(data)), 32'd0);
      else          check("bus_released", 32'(data), 32'hFF);
    end
  end

  // Issue one transaction; called at a negedge, returns at the negedge after IDLE is re-entered.
  task automatic txn(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d, input int stall);
    int n;
    int k;
    logic [DW-1:0] exp_rdata;
    exp_rdata = w ? last_rd : model_mem[a];
    bus.req_valid = 1'b1;
    bus.req_wr    = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.rsp_ready = (stall == 0);
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 32'(n < 50), 32'd1);
    wr_cycles = 0;
    rd_cycles = 0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        bus.req_valid = 1'b0;
        check("strobe_cs", 32'(cs), 32'd1);
        check("strobe_addr", 32'(addr), 32'(a));
        if (w) check("wr_bus_data", 32'(data), 32'(d));
      end
    end while (!bus.rsp_valid && k < 40);
    check("rsp_latency", k, w ? 32'd2 : 32'(L + 1));
    check("rsp_wr", 32'(bus.rsp_wr), 32'(w));
    check("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rdata));
    for (int i = 0; i < stall; i++) begin
      check("bp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_rdata", 32'(bus.rsp_rdata), 32'(exp_rdata));
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
      check("bp_strobes", 32'({cs, rd, wr}), 32'd0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("idle_req_ready", 32'(bus.req_ready), 32'd1);
    check("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("wr_pulse_len", wr_cycles, w ? 32'd1 : 32'd0);
    check("rd_pulse_len", rd_cycles, w ? 32'd0 : 32'(L));
    bus.rsp_ready = 1'b0;
    if (w) model_mem[a] = d;
    else   last_rd = exp_rdata;
  endtask

  initial begin
    logic [AW-1:0] ra;
    bit            rw;
    for (int i = 0; i < (1 << AW); i++) model_mem[i] = '0;
    last_rd       = '0;
    rst           = 1'b1;
    ram_clr       = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_strobes", 32'({cs, rd, wr}), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_data_z", 32'(data), 32'hFF);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_wr", 32'(bus.rsp_wr), 32'd0);
    check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    rst     = 1'b0;
    ram_clr = 1'b0;
    mon_en  = 1'b1;
    @(negedge clk);

    // Write then read back
    txn(1'b1, 10'h005, 8'hAA, 0);
    txn(1'b1, 10'h00A, 8'h55, 0);
    txn(1'b0, 10'h005, 8'h00, 0);
    check("readback_005", 32'(last_rd), 32'hAA);
    txn(1'b0, 10'h00A, 8'h00, 0);
    check("readback_00A", 32'(last_rd), 32'h55);

    // Back-pressure
    txn(1'b0, 10'h005, 8'h00, 3);

    // Busy request held while the first is in flight
    bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_addr = 10'h3FF; bus.req_wdata = 8'h3C;
    bus.rsp_ready = 1'b1;
    wr_cycles = 0;
    @(negedge clk);
    check("busy_wr1", 32'({wr, addr}), 32'({1'b1, 10'h3FF}));
    check("busy_rr1", 32'(bus.req_ready), 32'd0);
    bus.req_addr = 10'h000; bus.req_wdata = 8'hC3;
    @(negedge clk);
    check("busy_resp", 32'({bus.rsp_valid, bus.rsp_wr, wr}), 32'b110);
    check("busy_rr2", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check("busy_idle", 32'({bus.req_ready, cs}), 32'b10);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("busy_wr2", 32'({wr, addr}), 32'({1'b1, 10'h000}));
    check("busy_wr2_data", 32'(data), 32'hC3);
    repeat (2) @(negedge clk);
    check("busy_done", 32'({bus.req_ready, bus.rsp_valid}), 32'b10);
    check("busy_wr_count", wr_cycles, 32'd2);
    bus.rsp_ready = 1'b0;
    model_mem[10'h3FF] = 8'h3C;
    model_mem[10'h000] = 8'hC3;
    txn(1'b0, 10'h3FF, 8'h00, 0);
    check("read_3FF", 32'(last_rd), 32'h3C);
    txn(1'b0, 10'h000, 8'h00, 0);
    check("read_000", 32'(last_rd), 32'hC3);

    // Reset during the second rd cycle
    bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 10'h005; bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rr_rd1", 32'(rd), 32'd1);
    @(negedge clk);
    check("rr_rd2", 32'(rd), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rr_strobes", 32'({cs, rd, wr}), 32'd0);
    check("rr_data_z", 32'(data), 32'hFF);
    check("rr_req_ready", 32'(bus.req_ready), 32'd1);
    check("rr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    rst = 1'b0;
    last_rd = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rr_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    bus.rsp_ready = 1'b0;
    txn(1'b0, 10'h00A, 8'h00, 0);
    check("rr_read_00A", 32'(last_rd), 32'h55);

    // Randomized traffic against the array model
    for (int t = 0; t < 40; t++) begin
      rw = 1'(($urandom_range(0, 1)));
      case ($urandom_range(0, 3))
        0:       ra = '0;
        1:       ra = '1;
        default: ra = AW'($urandom_range(0, (1 << AW) - 1));
      endcase
      txn(rw, ra, DW'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
    end

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_ctrl.md
# ram_ctrl

Bus initiator for the single-port `ram` block. It accepts one read or write request at a time on a valid/ready request port and sequences `cs`/`rd`/`wr`/`addr` on the RAM pins. It owns the shared tri-state `data` bus and returns the read data or a write acknowledge on a valid/ready response port. It replaces the hand-driven bus sequencing currently done in benches, so that system logic can reach the RAM through a clean handshake.

## Interface
- `ADDR_WIDTH`, 10, RAM address width.
- `DATA_WIDTH`, 8, RAM data width.
- `RD_LATENCY`, 2, cycles that `cs`&`rd` stay asserted before read data is sampled; legal range 1..15.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_wr`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_WIDTH  target address.
- `req_wdata`  in  DATA_WIDTH  write data.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_wr`  out  1  response belongs to a write.
- `rsp_rdata`  out  DATA_WIDTH  read data; holds its last value on write responses.
- `addr`  out  ADDR_WIDTH  RAM address.
- `data`  inout  DATA_WIDTH  RAM data bus; driven only in WRITE, high-Z otherwise.
- `cs`, `rd`, `wr`  out  1 each  RAM chip select, read strobe and write strobe.

## Operation
- FSM states: IDLE, WRITE, READ, RESP.
- **IDLE**
  - `req_ready`=1; RAM strobes low; `data` high-Z.
  - On `req_valid`&`req_ready`, latch `req_wr`, `req_addr` and `req_wdata`.
  - Go to WRITE if `req_wr`=1, otherwise READ and load the wait counter with RD_LATENCY-1.
- **WRITE** (exactly 1 cycle)
  - `cs`=1, `wr`=1, `rd`=0; `addr` = latched address; `data` driven with latched wdata.
  - The RAM commits on the edge that ends this cycle.
  - Go to RESP with `rsp_wr`=1.
- **READ** (RD_LATENCY cycles)
  - `cs`=1, `rd`=1, `wr`=0; `addr` = latched address; `data` high-Z.
  - The counter decrements each cycle.
  - On the edge ending the cycle where the counter is 0, capture `data` into `rsp_rdata` and go to RESP with `rsp_wr`=0.
- **RESP**
  - `rsp_valid`=1; strobes low; `data` high-Z.
  - `rsp_valid`, `rsp_wr` and `rsp_rdata` stay stable until `rsp_valid`&`rsp_ready`, then go to IDLE.
- `req_ready`=0 in every state except IDLE. Requests presented while busy are not accepted; the requester must hold them.
- One transaction outstanding at most. There is no combinational path from `req_*` or `rsp_ready` to any output.
- `rd` and the `data` driver are never active in the same cycle, so there is no bus contention.
- Address is used as-is; 0 and 2^ADDR_WIDTH-1 need no special handling.
- **Reset**
  - State goes to IDLE; `cs`=`rd`=`wr`=0; `addr`=0; `data` high-Z.
  - `req_ready`=1, `rsp_valid`=0, `rsp_wr`=0, `rsp_rdata`=0.
  - Reset mid-transaction drops the request with no response. A write strobe cut short by reset is not guaranteed to commit.

## Timing
- All outputs are registered. The `data` output enable is derived from the state register only.
- Accept edge E0: the request is sampled at E0, and RAM strobes are active in the cycle following E0.
- **Write**
  - Strobes active E0→E1.
  - `rsp_valid` rises after E1.
  - With `rsp_ready` held 1, `req_ready` returns after E2, giving 3 cycles per write.
- **Read**
  - Strobes active E0→E(RD_LATENCY).
  - Sample at edge E(RD_LATENCY).
  - `rsp_valid` from E(RD_LATENCY) onward.
  - With `rsp_ready` held 1, back in IDLE after E(RD_LATENCY+1), giving RD_LATENCY+2 cycles per read (4 at default).
- Every transaction has one idle cycle between bus accesses (the RESP cycle), which is the bus turnaround.

## Test plan
- **Reset**: assert `rst` 2 cycles.
  - Required: `cs`/`rd`/`wr`=0, `data`=Z, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0.
- **Write then read back** through the `ram` model:
  - Write 0x005←0xAA, then write 0x00A←0x55.
  - Read 0x005 → `rsp_rdata`=0xAA, `rsp_wr`=0. Read 0x00A → 0x55.
  - Required: `wr` is high exactly 1 cycle per write; `rd` is high exactly RD_LATENCY cycles per read.
- **Back-pressure**: read 0x005 with `rsp_ready`=0 for 3 cycles.
  - Required: `rsp_valid`=1 and 0xAA stable for all 3 cycles, `req_ready`=0 throughout, strobes low.
  - Required: IDLE is reached on the edge after `rsp_ready`=1.
- **Busy requests and address extremes**: hold `req_valid`=1 with a second request while the first is active.
  - Required: the second request is accepted only on the first IDLE cycle.
  - Write 0x3FF←0x3C and 0x000←0xC3, then read both → 0x3C and 0xC3.
- **Reset during READ** (second cycle of `rd`):
  - Required: next cycle strobes are 0, `data`=Z, `rsp_valid` never asserts, `req_ready`=1.
  - A following read of 0x00A returns 0x55.
- **No contention**: over all scenarios, assert that the controller never drives `data` while `rd`=1, and that `data` is never X while `wr`=1.
